ps2_scan_receiver: RTL and testbench

PS2_SCAN_RECEIVER -- requirements
Module: ps2_scan_receiver

---
 rtl/ps2_pkg.sv | 23 ++
 rtl/ps2_code_fifo.sv | 59 +++++
 rtl/ps2_scan_receiver.sv | 188 ++++++++++++++++++
 tb/tb_ps2_scan_receiver.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver:
// frame FSM states, prefix byte values and the buffered entry layout.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_entry_t;

    localparam int ENTRY_W = $bits(ps2_entry_t);

endpackage

// File: rtl/ps2_code_fifo.sv
// Small synchronous FIFO of scan-code entries. A push into a full FIFO is
// dropped and flagged, unless a pop happens on the same edge.
module ps2_code_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [ENTRY_W-1:0]       wr_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [ENTRY_W-1:0]       rd_data,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    ps2_entry_t     mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           full;
    logic           pop;
    logic           push;

    assign full     = (count == (AW+1)'(DEPTH));
    assign rd_valid = (count != '0);
    assign pop      = rd_valid && rd_ready;
    assign push     = wr_en && (!full || pop);
    // Head is forced to zero when empty so the outputs have a defined reset value.
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= ps2_entry_t'(wr_data);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= wr_en && full && !pop;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 device-to-host receiver: synchronises the lines, decodes 11-bit frames,
// folds E0/F0 prefixes into flags and buffers the resulting scan codes.
module ps2_scan_receiver
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT     = 50000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [7:0]                    m_code,
    output logic                          m_ext,
    output logic                          m_brk,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_last;
    logic                   clk_s;
    logic                   data_s;
    logic                   fall_q;

    ps2_state_t             state, state_nx;
    logic [2:0]             bit_cnt, bit_nx;
    logic [7:0]             shift, shift_nx;
    logic [TW-1:0]          tcnt, tcnt_nx;
    logic                   perr_set, ferr_set, done_set;

    logic                   done_q;
    logic [7:0]             done_code;
    logic                   ext_pend, brk_pend;
    logic                   wr_en;
    ps2_entry_t             wr_entry;
    logic [ENTRY_W-1:0]     head;

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];
    assign fall_q = clk_last && !clk_s;

    // Synchronisers idle high, matching an undriven PS/2 line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_last  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_last  <= clk_s;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            tcnt       <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            done_q     <= 1'b0;
            done_code  <= '0;
        end else begin
            state      <= state_nx;
            bit_cnt    <= bit_nx;
            shift      <= shift_nx;
            tcnt       <= tcnt_nx;
            parity_err <= perr_set;
            frame_err  <= ferr_set;
            done_q     <= done_set;
            done_code  <= shift;
        end
    end

    always_comb begin
        state_nx = state;
        bit_nx   = bit_cnt;
        shift_nx = shift;
        tcnt_nx  = tcnt;
        perr_set = 1'b0;
        ferr_set = 1'b0;
        done_set = 1'b0;
        case (state)
            ST_IDLE: begin
                bit_nx  = '0;
                tcnt_nx = '0;
                if (fall_q && !data_s) begin
                    state_nx = ST_DATA;
                end
            end
            ST_DATA: begin
                if (fall_q) begin
                    shift_nx = {data_s, shift[7:1]};
                    bit_nx   = bit_cnt + 3'd1;
                    tcnt_nx  = '0;
                    if (bit_cnt == 3'd7) begin
                        state_nx = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (fall_q) begin
                    tcnt_nx = '0;
                    if (^{shift, data_s}) begin
                        state_nx = ST_STOP;
                    end else begin
                        perr_set = 1'b1;
                        state_nx = ST_IDLE;
                    end
                end
            end
            ST_STOP: begin
                if (fall_q) begin
                    done_set = data_s;
                    ferr_set = !data_s;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        // Inter-edge watchdog while a frame is in flight.
        if (state != ST_IDLE && !fall_q) begin
            if (tcnt == TW'(TIMEOUT - 1)) begin
                ferr_set = 1'b1;
                state_nx = ST_IDLE;
                tcnt_nx  = '0;
            end else begin
                tcnt_nx = tcnt + 1'b1;
            end
        end
    end

    assign wr_en         = done_q && (done_code != PS2_EXT) && (done_code != PS2_BRK);
    assign wr_entry.ext  = ext_pend;
    assign wr_entry.brk  = brk_pend;
    assign wr_entry.code = done_code;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (perr_set || ferr_set) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (done_q) begin
            if (done_code == PS2_EXT) begin
                ext_pend <= 1'b1;
            end else if (done_code == PS2_BRK) begin
                brk_pend <= 1'b1;
            end else begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end
        end
    end

    // m_valid/m_ready: an entry transfers on a rising clk edge where both are
    // high; the head fields hold steady while m_valid waits for m_ready.
    ps2_code_fifo #(
        .DEPTH    (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_entry),
        .rd_valid (m_valid),
        .rd_ready (m_ready),
        .rd_data  (head),
        .overflow (overflow),
        .count    (fifo_count)
    );

    assign m_ext  = head[9];
    assign m_brk  = head[8];
    assign m_code = head[7:0];

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Directed bench for ps2_scan_receiver: bit-banged PS/2 frames, a pop monitor
// feeding a received queue checked against an expected queue.
module tb_ps2_scan_receiver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_code;
    logic       m_ext;
    logic       m_brk;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;
    logic [2:0] fifo_count;

    int checks = 0;
    int errors = 0;
    int perr_cnt = 0;
    int ferr_cnt = 0;
    int ovf_cnt  = 0;
    int peak     = 0;
    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];

    ps2_scan_receiver #(
        .FIFO_DEPTH  (4),
        .TIMEOUT     (100),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_code     (m_code),
        .m_ext      (m_ext),
        .m_brk      (m_brk),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // Monitor on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (parity_err) perr_cnt = perr_cnt + 1;
            if (frame_err)  ferr_cnt = ferr_cnt + 1;
            if (overflow)   ovf_cnt  = ovf_cnt + 1;
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
            if (m_valid && m_ready) got_q.push_back({m_ext, m_brk, m_code});
        end
    end

    task automatic wait_clks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_stats();
        perr_cnt = 0;
        ferr_cnt = 0;
        ovf_cnt  = 0;
        peak     = 0;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        wait_clks(10);
        ps2_clk = 1'b0;
        wait_clks(10);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input logic bad_par);
        logic [7:0] c;
        c = code;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(c[i]);
        ps2_bit((~^c) ^ bad_par);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        wait_clks(20);
    endtask

    task automatic check_queue(input string name);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL %s count: got %0d entries, expected %0d", name, got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL %s entry %0d: got %h, expected %h", name, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic check_counts(input string name, input int pe, input int fe, input int ov);
        checks++;
        if (perr_cnt !== pe || ferr_cnt !== fe || ovf_cnt !== ov) begin
            errors++;
            $display("FAIL %s pulses: got perr=%0d ferr=%0d ovf=%0d, expected %0d %0d %0d",
                     name, perr_cnt, ferr_cnt, ovf_cnt, pe, fe, ov);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({m_valid, m_code, m_ext, m_brk} !== 11'h0) begin
            errors++;
            $display("FAIL %s head: got valid=%b code=%h ext=%b brk=%b, expected all 0",
                     name, m_valid, m_code, m_ext, m_brk);
        end
        checks++;
        if ({parity_err, frame_err, overflow} !== 3'b000 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL %s flags: got perr=%b ferr=%b ovf=%b count=%0d, expected 0",
                     name, parity_err, frame_err, overflow, fifo_count);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        m_ready = 1'b0;
        wait_clks(5);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        wait_clks(5);
    endtask

    task automatic test_single();
        clear_stats();
        m_ready = 1'b1;
        exp_q.push_back({2'b00, 8'h1C});
        send_frame(8'h1C, 1'b0);
        check_queue("single_1c");
        check_counts("single_1c", 0, 0, 0);
    endtask

    task automatic test_prefix();
        clear_stats();
        m_ready = 1'b1;
        exp_q.push_back({2'b11, 8'h75});
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        check_queue("prefix_e0f075");
        checks++;
        if (peak !== 1) begin
            errors++;
            $display("FAIL prefix_peak: got %0d, expected 1", peak);
        end
        check_counts("prefix_e0f075", 0, 0, 0);
    endtask

    task automatic test_parity();
        clear_stats();
        m_ready = 1'b1;
        send_frame(8'h1C, 1'b1);
        check_queue("parity_drop");
        check_counts("parity_drop", 1, 0, 0);
        // A parity failure after F0 must discard the pending break flag.
        clear_stats();
        exp_q.push_back({2'b00, 8'h1C});
        exp_q.push_back({2'b01, 8'h1C});
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b1);
        send_frame(8'h1C, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        check_queue("parity_clears_brk");
        check_counts("parity_clears_brk", 1, 0, 0);
    endtask

    task automatic test_timeout();
        int first;
        clear_stats();
        m_ready = 1'b1;
        first = -1;
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_data = 1'b1;
        wait_clks(10);
        ps2_clk = 1'b0;
        // Two synchroniser flops plus the edge register put the watchdog
        // start on the 3rd clk edge; it fires 100 edges later.
        for (int n = 1; n <= 140; n++) begin
            wait_clks(1);
            if (n == 10) ps2_clk = 1'b1;
            if (frame_err && first < 0) first = n;
        end
        checks++;
        if (first !== 103) begin
            errors++;
            $display("FAIL timeout_latency: got edge %0d, expected 103", first);
        end
        check_counts("timeout", 0, 1, 0);
        exp_q.push_back({2'b00, 8'h29});
        send_frame(8'h29, 1'b0);
        check_queue("after_timeout_29");
        check_counts("after_timeout_29", 0, 1, 0);
    endtask

    task automatic test_overflow();
        clear_stats();
        m_ready = 1'b0;
        send_frame(8'h16, 1'b0);
        send_frame(8'h1E, 1'b0);
        send_frame(8'h26, 1'b0);
        send_frame(8'h25, 1'b0);
        send_frame(8'h2E, 1'b0);
        checks++;
        if (fifo_count !== 3'd4) begin
            errors++;
            $display("FAIL overflow_count: got %0d, expected 4", fifo_count);
        end
        checks++;
        if (m_valid !== 1'b1 || m_code !== 8'h16) begin
            errors++;
            $display("FAIL overflow_head: got valid=%b code=%h, expected 1 16", m_valid, m_code);
        end
        check_counts("overflow", 0, 0, 1);
        exp_q.push_back({2'b00, 8'h16});
        exp_q.push_back({2'b00, 8'h1E});
        exp_q.push_back({2'b00, 8'h26});
        exp_q.push_back({2'b00, 8'h25});
        m_ready = 1'b1;
        wait_clks(10);
        check_queue("overflow_drain");
        checks++;
        if (fifo_count !== 3'd0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL overflow_empty: got count=%0d valid=%b, expected 0 0", fifo_count, m_valid);
        end
    endtask

    task automatic test_reset_mid();
        clear_stats();
        m_ready = 1'b1;
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        rst_n = 1'b0;
        wait_clks(1);
        check_reset_outputs("reset_mid");
        rst_n = 1'b1;
        wait_clks(150);
        check_counts("reset_mid_quiet", 0, 0, 0);
        exp_q.push_back({2'b00, 8'h1C});
        send_frame(8'h1C, 1'b0);
        check_queue("reset_mid_1c");
        check_counts("reset_mid_1c", 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_prefix();
        test_parity();
        test_timeout();
        test_overflow();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
